// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
// Screen-buffer front end for the character-LCD displayer. Holds a 2x16
// character buffer that the application may write at any time and, on a
// refresh request, sweeps all 32 positions issuing one character/address
// command per position over the displayer's start/busy handshake.
//
// Optional feature macro: LCD_SEQ_DIRTY_SKIP_EN
//   When defined, a dirty vector tracks which positions changed since they
//   were last sent, and a SCAN step skips clean positions (one cycle each,
//   no command). When undefined, every refresh sends all 32 positions.

module lcd_text_sequencer (
  input  logic       i_clk_800k,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_idx,
  input  logic [7:0] i_wr_char,
  input  logic       i_refresh,
  output logic       o_start,
  output logic [7:0] o_character,
  output logic [7:0] o_address,
  input  logic       i_busy,
  output logic       o_sweeping,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  // Each position is entered through SCAN when skipping is enabled, so the
  // dirty check happens before any command is driven.
`ifdef LCD_SEQ_DIRTY_SKIP_EN
  localparam state_t L_ENTRY = S_SCAN;
`else
  localparam state_t L_ENTRY = S_ISSUE;
`endif

  localparam logic [4:0] L_LAST_IDX = 5'd31;

  logic [7:0] r_buf [0:31];
  logic [4:0] r_idx;
  logic       r_refresh_pend;
  state_t     r_state;

  // Line 1 lives at DDRAM 0x00.., line 2 at 0x40..
  function automatic logic [7:0] map_addr(input logic [4:0] idx);
    return idx[4] ? {4'h4, idx[3:0]} : {4'h0, idx[3:0]};
  endfunction

  // Screen buffer: written by the application in every state.
  always_ff @(posedge i_clk_800k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else begin
      if (i_wr_en) begin
        r_buf[i_wr_idx] <= i_wr_char;
      end
    end
  end

`ifdef LCD_SEQ_DIRTY_SKIP_EN
  logic [31:0] r_dirty;

  // Dirty tracking: sending a position cleans it, a write dirties it; a
  // write landing in the same cycle as the send wins so it is not lost.
  always_ff @(posedge i_clk_800k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dirty <= {32{1'b1}};
    end else begin
      if ((r_state == S_ISSUE) && !i_busy) begin
        r_dirty[r_idx] <= 1'b0;
      end
      if (i_wr_en) begin
        r_dirty[i_wr_idx] <= 1'b1;
      end
    end
  end
`endif

  // Sweep controller with registered handshake and status outputs.
  always_ff @(posedge i_clk_800k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_idx          <= 5'd0;
      r_refresh_pend <= 1'b0;
      o_start        <= 1'b0;
      o_character    <= 8'h20;
      o_address      <= 8'h00;
      o_sweeping     <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      o_start <= 1'b0;
      o_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_refresh || r_refresh_pend) begin
            r_state        <= L_ENTRY;
            r_idx          <= 5'd0;
            r_refresh_pend <= 1'b0;
            o_sweeping     <= 1'b1;
          end
        end

`ifdef LCD_SEQ_DIRTY_SKIP_EN
        S_SCAN: begin
          if (r_dirty[r_idx]) begin
            r_state <= S_ISSUE;
          end else if (r_idx == L_LAST_IDX) begin
            r_state    <= S_FINISH;
            o_done     <= 1'b1;
            o_sweeping <= 1'b0;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
`endif

        S_ISSUE: begin
          // Busy is high through displayer power-up, so the first command
          // naturally waits here until init is over.
          if (!i_busy) begin
            o_character <= r_buf[r_idx];
            o_address   <= map_addr(r_idx);
            o_start     <= 1'b1;
            r_state     <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (i_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (!i_busy) begin
            if (r_idx == L_LAST_IDX) begin
              r_state    <= S_FINISH;
              o_done     <= 1'b1;
              o_sweeping <= 1'b0;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= L_ENTRY;
            end
          end
        end

        S_FINISH: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state    <= S_IDLE;
          o_sweeping <= 1'b0;
        end
      endcase

      // Requests arriving mid-sweep collapse into one follow-up sweep.
      if (i_refresh && (r_state != S_IDLE)) begin
        r_refresh_pend <= 1'b1;
      end
    end
  end

endmodule
